// File: rtl/apb_slave_regfile.sv
// APB completer with a resettable register file, own-slot select decode and fixed wait states.
// Optional APB_SLAVE_PSLVERR_EN: bad (misaligned / out-of-range) accesses raise pslverr with pready.
module apb_slave_regfile #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 16,
    parameter int SEL_IDX     = 0,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic [2:0]        psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr
);

    localparam int         IDX_W   = $clog2(DEPTH);
    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);
`ifdef APB_SLAVE_PSLVERR_EN
    localparam bit         ERR_EN  = 1'b1;
`else
    localparam bit         ERR_EN  = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_READY
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              bad_q, bad_d;
    logic              write_q, write_d;
    logic [DATA_W-1:0] prdata_q, prdata_d;
    logic              pready_q, pready_d;
    logic              pslverr_q, pslverr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic sel;
    logic setup;
    logic addr_bad;
    logic wr_en;
    logic unused_ok;

    assign sel       = psel[SEL_IDX];
    assign setup     = sel & ~penable;
    // Anything above the word index, or a non-word-aligned byte offset, is out of this file.
    assign addr_bad  = (paddr[1:0] != 2'b00) | (|(paddr >> (2 + IDX_W)));
    assign unused_ok = ^psel;

    // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        bad_d     = bad_q;
        write_d   = write_q;
        case (state_q)
            S_IDLE: begin
                if (setup) begin
                    idx_d   = paddr[2 +: IDX_W];
                    bad_d   = addr_bad;
                    write_d = pwrite;
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_READY;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_LD;
                    end
                end
            end
            S_WAIT: begin
                if (!sel) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_d = S_READY;
                end
            end
            S_READY: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // READY always lasts one cycle, so state_d == READY means "entering READY".
        pready_d  = (state_d == S_READY);
        pslverr_d = ERR_EN && (state_d == S_READY) && bad_d;
        prdata_d  = (state_d == S_READY && !write_d && !bad_d) ? mem_q[idx_d] : '0;
    end

    // Abort (sel dropped) and bad accesses both suppress the commit.
    assign wr_en = (state_q == S_READY) && sel && penable && write_q && !bad_q;

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            bad_q     <= 1'b0;
            write_q   <= 1'b0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            bad_q     <= bad_d;
            write_q   <= write_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
        end
    end

    // NOTE: the register file must read 0 after reset, so it is built from resettable flops, not a RAM.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[idx_q] <= pwdata;
        end
    end

    assign prdata  = prdata_q;
    assign pready  = pready_q;
    assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Scoreboard bench: three completers on one APB bus (slots 0/1/2 with 0/3/2 wait states).
// Expected pslverr follows APB_SLAVE_PSLVERR_EN.
module tb_apb_slave_regfile;

`ifdef APB_SLAVE_PSLVERR_EN
    localparam logic ERR = 1'b1;
`else
    localparam logic ERR = 1'b0;
`endif

    typedef struct {
        int          inst;
        logic [31:0] rdata;
        logic        err;
        longint      cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        presetn;
    logic [2:0]  psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata  [3];
    logic        pready  [3];
    logic        pslverr [3];

    exp_t   sb[$];
    longint cyc = 0;
    int     checks = 0;
    int     failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    apb_slave_regfile #(.SEL_IDX(0), .WAIT_CYCLES(0)) u_s0 (
        .pclk(clk), .presetn(presetn), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata[0]), .pready(pready[0]), .pslverr(pslverr[0]));
    apb_slave_regfile #(.SEL_IDX(1), .WAIT_CYCLES(3)) u_s1 (
        .pclk(clk), .presetn(presetn), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata[1]), .pready(pready[1]), .pslverr(pslverr[1]));
    apb_slave_regfile #(.SEL_IDX(2), .WAIT_CYCLES(2)) u_s2 (
        .pclk(clk), .presetn(presetn), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata[2]), .pready(pready[2]), .pslverr(pslverr[2]));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int waits_of(input int inst);
        return (inst == 1) ? 3 : (inst == 2) ? 2 : 0;
    endfunction

    // One complete APB transfer; next call starts its setup phase in the cycle after READY.
    task automatic xfer(input int inst, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_err);
        exp_t e;
        int   n = 0;
        psel    = 3'(1 << inst);
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = wdata;
        e.inst  = inst;
        e.rdata = exp_rd;
        e.err   = exp_err;
        e.cyc   = cyc + 1 + longint'(waits_of(inst));
        sb.push_back(e);
        @(posedge clk); #1;
        penable = 1'b1;
        while (!pready[inst] && n < 32) begin
            @(posedge clk); #1;
            n++;
        end
        check("xfer_done", 64'(pready[inst]), 64'd1);
        @(posedge clk); #1;
        psel    = 3'b000;
        penable = 1'b0;
    endtask

    // Monitor: every pready pops one expectation; outputs must be quiet otherwise.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (pready[i]) begin
                if (sb.size() == 0) begin
                    check("spurious_pready", 64'(pready[i]), 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("ready_slot", 64'(i), 64'(e.inst));
                    check("ready_cycle", 64'(cyc), 64'(e.cyc));
                    check("prdata", 64'(prdata[i]), 64'(e.rdata));
                    check("pslverr", 64'(pslverr[i]), 64'(e.err));
                end
            end else if (pslverr[i] || prdata[i] != 32'd0) begin
                check("idle_outputs_zero", {31'd0, pslverr[i], prdata[i]}, 64'd0);
            end
        end
    end

    initial begin
        presetn = 1'b0;
        psel    = 3'b000;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pready", 64'(pready[0]), 64'd0);
        check("rst_prdata", 64'(prdata[0]), 64'd0);
        check("rst_pslverr", 64'(pslverr[0]), 64'd0);
        presetn = 1'b1;
        @(posedge clk); #1;

        // zero-wait round trip
        xfer(0, 1'b1, 32'h0C, 32'hDEAD_BEEF, 32'h0, 1'b0);
        xfer(0, 1'b0, 32'h0C, 32'h0, 32'hDEAD_BEEF, 1'b0);

        // three wait states
        xfer(1, 1'b0, 32'h04, 32'h0, 32'h0, 1'b0);
        xfer(1, 1'b1, 32'h04, 32'hCAFE_0004, 32'h0, 1'b0);
        xfer(1, 1'b0, 32'h04, 32'h0, 32'hCAFE_0004, 1'b0);

        // back-to-back write then read of index 0
        xfer(0, 1'b1, 32'h00, 32'h11, 32'h0, 1'b0);
        xfer(0, 1'b0, 32'h00, 32'h0, 32'h11, 1'b0);

        // bad accesses: out-of-range, misaligned, top address bit
        xfer(0, 1'b1, 32'h40, 32'h77, 32'h0, ERR);
        xfer(0, 1'b1, 32'h01, 32'h99, 32'h0, ERR);
        xfer(0, 1'b0, 32'h00, 32'h0, 32'h11, 1'b0);
        xfer(0, 1'b0, 32'h02, 32'h0, 32'h0, ERR);
        xfer(0, 1'b0, 32'h8000_0000, 32'h0, 32'h0, ERR);
        xfer(0, 1'b1, 32'h3C, 32'hA5A5_A5A5, 32'h0, 1'b0);
        xfer(0, 1'b0, 32'h3C, 32'h0, 32'hA5A5_A5A5, 1'b0);

        // select decode: slot-0 write must not reach slot 2
        xfer(0, 1'b1, 32'h08, 32'hAA, 32'h0, 1'b0);
        xfer(2, 1'b0, 32'h08, 32'h0, 32'h0, 1'b0);
        xfer(0, 1'b0, 32'h08, 32'h0, 32'hAA, 1'b0);

        // abort: drop psel[2] during WAIT, no write, no pready
        xfer(2, 1'b1, 32'h04, 32'h55, 32'h0, 1'b0);
        psel = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 32'h04; pwdata = 32'h99;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        psel = 3'b000; penable = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        xfer(2, 1'b0, 32'h04, 32'h0, 32'h55, 1'b0);

        // reset while READY: outputs drop at once
        psel = 3'b001; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0C;
        @(posedge clk); #1;
        penable = 1'b1;
        check("pre_rst_pready", 64'(pready[0]), 64'd1);
        check("pre_rst_prdata", 64'(prdata[0]), 64'hDEAD_BEEF);
        presetn = 1'b0;
        #1;
        check("rst_ready_pready", 64'(pready[0]), 64'd0);
        check("rst_ready_prdata", 64'(prdata[0]), 64'd0);
        psel = 3'b000; penable = 1'b0;
        @(posedge clk); #1;
        presetn = 1'b1;
        @(posedge clk); #1;

        // reset during WAIT of slot 1
        psel = 3'b010; penable = 1'b0; pwrite = 1'b0; paddr = 32'h04;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        presetn = 1'b0;
        #1;
        check("rst_wait_pready", 64'(pready[1]), 64'd0);
        check("rst_wait_prdata", 64'(prdata[1]), 64'd0);
        check("rst_wait_pslverr", 64'(pslverr[1]), 64'd0);
        psel = 3'b000; penable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        presetn = 1'b1;
        @(posedge clk); #1;

        // register file cleared by reset
        xfer(0, 1'b0, 32'h0C, 32'h0, 32'h0, 1'b0);
        xfer(0, 1'b0, 32'h00, 32'h0, 32'h0, 1'b0);
        xfer(1, 1'b0, 32'h04, 32'h0, 32'h0, 1'b0);

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb_slave_regfile.md
# apb_slave_regfile

Parametrised APB completer that replaces the fixed, combinational, random-data APB slave model on the APB side of the AHB-to-APB bridge. It holds a readable and writable register file, decodes its own select line out of the bridge's one-hot `psel` bus and inserts a configurable number of wait states through `pready`. It can optionally flag out-of-range or misaligned accesses on `pslverr`. One instance is placed per APB peripheral slot in the bridge test environment.

## Interface
- `DATA_W`, default 32: data bus width in bits; must be a multiple of 8.
- `ADDR_W`, default 32: `paddr` width.
- `DEPTH`, default 16: number of `DATA_W`-bit registers; must be a power of two, at least 2.
- `SEL_IDX`, default 0: the bit of `psel` that selects this instance (0..2).
- `WAIT_CYCLES`, default 0: wait states inserted per transfer (0..15).
- `pclk`  in  1  APB clock; all state is updated on the rising edge.
- `presetn`  in  1  asynchronous, active-low reset.
- `psel`  in  3  one-hot slave selects from the bridge; only `psel[SEL_IDX]` is used.
- `penable`  in  1  APB enable (access phase).
- `pwrite`  in  1  1 = write, 0 = read.
- `paddr`  in  `ADDR_W`  byte address.
- `pwdata`  in  `DATA_W`  write data.
- `prdata`  out  `DATA_W`  read data; registered.
- `pready`  out  1  transfer complete; registered.
- `pslverr`  out  1  transfer error; registered. Tied 0 unless `APB_SLAVE_PSLVERR_EN` is defined.

## Operation
- **Decode:**
  - `sel = psel[SEL_IDX]`.
  - Word index = `paddr[2 +: log2(DEPTH)]`; the bits below that word index are the byte offset.
  - An access is *bad* if `paddr[1:0] != 0`, or if any `paddr` bit at position `2+log2(DEPTH)` or above is set.
- **FSM states:** IDLE, WAIT, READY.
  - IDLE to READY on `sel & !penable` (setup phase) when `WAIT_CYCLES == 0`.
  - IDLE to WAIT on `sel & !penable` when `WAIT_CYCLES > 0`; the wait counter is loaded with `WAIT_CYCLES`.
  - WAIT: the counter decrements each cycle. WAIT to READY when the counter equals 1.
  - READY to IDLE unconditionally (transfer completes this cycle).
  - WAIT or READY to IDLE immediately if `sel` drops (protocol abort). An aborted transfer performs no write.
- **Address and control capture:** `paddr` and `pwrite` are captured at the setup edge. Changes to either during the access phase are ignored.
- **Write:** commits to `mem[index]` on the rising edge ending the READY cycle when `sel & penable & pwrite` holds and the access is not bad.
- **Read:** `prdata` is loaded from `mem[index]` on the edge entering READY. It reads 0 if the access is bad.
- **Output levels by state:**
  - `prdata` is 0 in every state other than READY, and during writes.
  - `pready` is high only in READY.
  - `pslverr` is high only in READY for a bad access, and only when the macro is defined.
- **Bad writes:** never modify any register.
- **Back-to-back transfers:** a new setup phase in the cycle after READY is accepted from IDLE with no dead cycle.
- **Reset:** `presetn` low, including mid-transfer, immediately forces the state to IDLE. It clears the counter, all `mem` entries, `prdata`, `pready` and `pslverr` to 0.

## Timing
- Setup in cycle T; `pready` is high in cycle T+1+`WAIT_CYCLES` for exactly one cycle.
- Read data is valid in the same cycle that `pready` is high.
- A read issued in the cycle directly after a write to the same address returns the new data.
- `penable` is not required for the IDLE to WAIT or IDLE to READY transitions. It is required for the write commit.

## Configuration
- `APB_SLAVE_PSLVERR_EN` defined:
  - Bad accesses complete normally with `pslverr = 1` alongside `pready`.
  - `prdata` is 0 for a bad access.
  - A bad write leaves the register file unchanged.
- `APB_SLAVE_PSLVERR_EN` undefined:
  - `pslverr` is constant 0.
  - Bad accesses still complete with `pready`; reads return 0 and writes are dropped silently.

## Test plan
- **Reset:** assert `presetn = 0` during a WAIT state. Required: `prdata`, `pready` and `pslverr` are 0 immediately. After release, a read of index 3 returns 0.
- **Zero-wait round trip (`WAIT_CYCLES = 0`):**
  - Write `0xDEADBEEF` to `paddr 0x0C`. Required: `pready` is high in cycle T+1.
  - Then read `0x0C`. Required: `prdata = 0xDEADBEEF` with `pready`.
- **Wait states (`WAIT_CYCLES = 3`):** read `0x04`. Required: `pready` is low for cycles T+1..T+3 and high in T+4 only.
- **Error, with `APB_SLAVE_PSLVERR_EN` defined (`DEPTH = 16`):**
  - Write `0x40`. Required: `pslverr = 1` with `pready`, and no register changes.
  - Read `0x02`. Required: `pslverr = 1`, `prdata = 0`.
  - Rebuild without the macro. Required: `pslverr` stays 0 for the same accesses.
- **Select and abort (`SEL_IDX = 2`):**
  - Drive `psel = 3'b001`. Required: no `pready`, no write.
  - Drop `psel[2]` during WAIT. Required: return to IDLE, `pready` stays 0, the target register is unchanged.
- **Back-to-back (`WAIT_CYCLES = 0`):** write `0x11` to `0x0`, then in the following cycle set up a read of `0x0`. Required: the read's `pready` arrives 2 cycles after the write's, with `prdata = 0x11`.
